mem_fifo_ctrl: RTL and testbench

MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

---
 rtl/mem_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_mem_fifo_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller driving an external block RAM (registered read, 1-cycle latency).
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module mem_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              rd_pending;
    logic              push_acc;
    logic              pop_acc;

    assign full  = (cnt == DEPTH_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

    // Enables are gated by rst so the RAM is never touched while in reset.
    assign push_acc = push && !full && !rst;
    assign pop_acc  = pop && !empty && !rst;

    assign mem_w_en   = push_acc;
    assign mem_w_addr = wr_ptr;
    assign mem_w_data = push_data;
    assign mem_r_en   = pop_acc;
    assign mem_r_addr = rd_ptr;

    assign pop_valid = rd_pending;
    assign pop_data  = mem_r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            rd_pending <= pop_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push && full) begin
                overflow_r <= 1'b1;
            end
            if (pop && empty) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl: a queue-based reference model plus a
// behavioural registered-read RAM attached to the memory ports.
module tb_mem_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              pop;
    logic              pop_valid;
    logic [DATA_W-1:0] pop_data;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_r_data;
    logic              overflow;
    logic              underflow;

    mem_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .full       (full),
        .pop        (pop),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .empty      (empty),
        .count      (count),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM stand-in: synchronous write, registered read.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= ram[mem_r_addr];
    end

    // Reference model state
    logic [DATA_W-1:0] q_m [$];
    int                wptr_m;
    int                rptr_m;
    bit                exp_pv;
    logic [DATA_W-1:0] exp_pd;
    bit                ovf_m;
    bit                unf_m;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        wptr_m = 0;
        rptr_m = 0;
        exp_pv = 1'b0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, then advance the model past the edge.
    task automatic do_cycle(input bit r, input bit p, input logic [DATA_W-1:0] d, input bit q);
        bit acc_p;
        bit acc_q;
        int sz;
        rst       = r;
        push      = p;
        push_data = d;
        pop       = q;
        sz    = q_m.size();
        acc_p = !r && p && (sz < DEPTH);
        acc_q = !r && q && (sz > 0);
        @(negedge clk);
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
        if (exp_pv) chk("pop_data", 32'(pop_data), 32'(exp_pd));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("underflow", 32'(underflow), 32'(unf_m));
        chk("mem_w_en", 32'(mem_w_en), 32'(acc_p));
        chk("mem_r_en", 32'(mem_r_en), 32'(acc_q));
        if (acc_p) begin
            chk("mem_w_addr", 32'(mem_w_addr), 32'(wptr_m));
            chk("mem_w_data", 32'(mem_w_data), 32'(d));
        end
        if (acc_q) chk("mem_r_addr", 32'(mem_r_addr), 32'(rptr_m));
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
`ifdef FIFO_ERR_FLAGS_EN
            if (p && sz == DEPTH) ovf_m = 1'b1;
            if (q && sz == 0)     unf_m = 1'b1;
`endif
            if (acc_q) begin
                exp_pd = q_m.pop_front();
                rptr_m = (rptr_m + 1) % DEPTH;
            end
            if (acc_p) begin
                q_m.push_back(d);
                wptr_m = (wptr_m + 1) % DEPTH;
            end
            exp_pv = acc_q;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Requests held high during reset must not reach the RAM.
        do_cycle(1'b1, 1'b1, 8'h33, 1'b1);
        do_cycle(1'b1, 1'b1, 8'h44, 1'b1);

        // Pop on empty right after reset.
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Fill, then a rejected 17th push.
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 8'(i), 1'b0);
        do_cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Drain back-to-back; the rejected 0xA5 must not appear.
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Pointer wrap.
        do_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Steady push+pop at count 5, plus the empty/full simultaneous corners.
        do_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h5A, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 11; i++) do_cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        do_cycle(1'b0, 1'b1, 8'hC3, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset in the cycle right after a pop.
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        do_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 60,
                     8'($urandom),
                     $urandom_range(0, 99) < 50);
        end
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
